// File: rtl/dp_cmd_sched.sv
// Round-robin command scheduler for the shared 8x16 register-array datapath.
// Issue one cycle after accept, done SETTLE_CYCLES later; req_ready is only offered while idle.
module dp_cmd_sched #(
  parameter int NUM_REQ       = 4,
  parameter int NUM_REGS      = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_op,
  input  logic [NUM_REQ*8-1:0]       req_addr,
  input  logic [NUM_REQ*16-1:0]      req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 dp_op_code,
  output logic [7:0]                 dp_address,
  output logic [15:0]                dp_data,
  output logic                       done_valid,
  output logic [$clog2(NUM_REQ)-1:0] done_id,
  output logic                       done_err,
  output logic                       busy
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CW    = ID_W + 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  rr_ptr, win_id, cur_id;
  logic             win_vld, cur_err, cmd_legal, done_nxt;
  logic [CW-1:0]    cand;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       win_op, win_addr, op_nxt, addr_nxt;
  logic [15:0]      win_data, data_nxt;

  // Search rr_ptr+1, rr_ptr+2, ... wrapping; cand never exceeds 2*NUM_REQ-1.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!win_vld && req_valid[cand[ID_W-1:0]]) begin
        win_vld = 1'b1;
        win_id  = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    win_op    = '0;
    win_addr  = '0;
    win_data  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == ID_W'(i)) begin
        win_op   = req_op[8*i +: 8];
        win_addr = req_addr[8*i +: 8];
        win_data = req_data[16*i +: 16];
      end
      req_ready[i] = rst_n && (state == IDLE) && win_vld && (win_id == ID_W'(i));
    end
    cmd_legal = (win_op >= 8'd1) && (win_op <= 8'd4) && (32'(win_addr) < NUM_REGS);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    op_nxt    = '0;
    addr_nxt  = '0;
    data_nxt  = '0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = ISSUE;
          // Rejected commands still take a slot but present NOP to the datapath.
          if (cmd_legal) begin
            op_nxt   = win_op;
            addr_nxt = win_addr;
            data_nxt = win_data;
          end
        end
      end
      ISSUE: begin
        state_nxt = SETTLE;
        cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
        done_nxt  = (SETTLE_CYCLES == 1);
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt  = cnt - CNT_W'(1);
          done_nxt = (cnt == CNT_W'(1));
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      cnt        <= '0;
      cur_id     <= '0;
      cur_err    <= 1'b0;
      dp_op_code <= '0;
      dp_address <= '0;
      dp_data    <= '0;
      done_valid <= 1'b0;
      done_id    <= '0;
      done_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dp_op_code <= op_nxt;
      dp_address <= addr_nxt;
      dp_data    <= data_nxt;
      done_valid <= done_nxt;
      if (state == IDLE && win_vld) begin
        rr_ptr  <= win_id;
        cur_id  <= win_id;
        cur_err <= !cmd_legal;
      end
      if (done_nxt) begin
        done_id  <= cur_id;
        done_err <= cur_err;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/dp_cmd_sched.md
Name: dp_cmd_sched

Overview:
- Round-robin scheduler sharing the single register-array datapath (8 x 16-bit regs; ops 1=write, 2=shr1, 3=shl1, 4=invert) among NUM_REQ command requesters.
- Accepts one command per requester via valid/ready and drives the datapath op_code/address/data inputs for exactly one cycle.
- Holds NOP (op_code 0) while the datapath settles, then reports completion.
- Rejects illegal commands without touching the datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_REGS, 8, number of datapath registers; legal addresses are 0..NUM_REGS-1.
- SETTLE_CYCLES, 2, NOP cycles after each issue before completion (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_op  in  NUM_REQ*8  op codes, requester i at [8i+7:8i].
- req_addr  in  NUM_REQ*8  register addresses, packed as req_op.
- req_data  in  NUM_REQ*16  operand data, requester i at [16i+15:16i].
- req_ready  out  NUM_REQ  one-hot accept; combinational.
- dp_op_code  out  8  to datapath op_code; registered.
- dp_address  out  8  to datapath address; registered.
- dp_data  out  16  to datapath data; registered.
- done_valid  out  1  single-cycle completion pulse; registered.
- done_id  out  clog2(NUM_REQ)  requester index of the completed command.
- done_err  out  1  qualifies done_valid: command was rejected.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release) values:
  - state=IDLE, rr_ptr=NUM_REQ-1, so requester 0 wins first.
  - dp_op_code=0, dp_address=0, dp_data=0.
  - done_valid=0, done_id=0, done_err=0, busy=0, req_ready=0.
- FSM has three states: IDLE, ISSUE, SETTLE.
- IDLE:
  - If any req_valid, grant the first valid index searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - req_ready[winner]=1 in that same cycle (cycle T); all other ready bits are 0.
  - On the clock edge: latch op/addr/data/id, set rr_ptr=winner, go to ISSUE.
  - With no valid requests, stay in IDLE with req_ready=0.
  - req_ready is 0 in every state except IDLE.
- Legality check at latch: legal = (op in 1..4) && (addr < NUM_REGS).
- ISSUE (cycle T+1), lasts one cycle:
  - Legal: dp_op_code/dp_address/dp_data = latched command.
  - Illegal: dp_op_code=0, dp_address=0, dp_data=0, and err is recorded.
  - Then go to SETTLE with settle counter = SETTLE_CYCLES-1.
- SETTLE (cycles T+2 .. T+1+SETTLE_CYCLES):
  - dp_op_code=0, dp_address=0, dp_data=0.
  - Counter decrements each cycle.
  - In the final SETTLE cycle: done_valid=1, done_id=latched id, done_err=recorded err.
  - Next state is IDLE.
- done_id and done_err hold their last values when done_valid=0.
- Throughput: one command per SETTLE_CYCLES+2 cycles. Latency from accept to done is SETTLE_CYCLES+1 cycles.
- Handshake:
  - Transfer occurs only when req_valid[i] && req_ready[i].
  - A requester must hold valid and payload stable until accepted.
  - Dropping valid before acceptance is legal; the command is simply not taken.
  - Payload is sampled only in the accept cycle; changes afterwards do not affect the issued command.
- Fairness: a continuously valid requester is granted within NUM_REQ grants.
- rr_ptr updates only on acceptance; rejected commands still advance rr_ptr.
- Reset asserted mid-ISSUE or mid-SETTLE:
  - Outputs return immediately to reset values.
  - The in-flight command produces no done pulse.
  - After release, the first grant goes to the lowest-index valid requester.
- Widths: dp_* are zero-extended copies of latched fields; no arithmetic is done on data.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1 -> req_ready=0, dp_op_code=0, done_valid=0, busy=0. Release -> requester 0 is accepted in the first IDLE cycle.
- Single legal command: req 1 with op=2, addr=3, data=0x00F0 at cycle T -> req_ready=4'b0010 at T.
  - At T+1: dp_op_code=2, dp_address=3, dp_data=0x00F0.
  - T+2 and T+3: dp_op_code=0.
  - At T+3: done_valid=1, done_id=1, done_err=0.
  - Datapath reg[3] ends as 0x0078.
- Round-robin: all 4 requesters valid continuously with op=1 -> grant order 0,1,2,3,0,1, with accept cycles spaced exactly 4 cycles apart.
- Illegal commands:
  - op=5, addr=2 -> ISSUE cycle shows dp_op_code=0; done_err=1; datapath registers unchanged.
  - op=1, addr=9 -> same result, done_err=1.
- Reset mid-operation: assert rst_n=0 during the first SETTLE cycle -> done_valid never pulses for that command; after release, lowest-index valid requester is accepted.
- Late payload change: req 2 changes data after acceptance -> issued dp_data equals the value sampled in the accept cycle. Requester 0 deasserting valid before acceptance -> it is skipped; the next valid requester is granted.
